// File: rtl/dzcpu_pkg.sv
// Shared flow-control codes, sequencer state encoding and default widths for the dzcpu
// micro-sequencer.
package dzcpu_pkg;

    localparam int unsigned UaddrWDefault = 8;

    localparam logic [3:0] FlowOp          = 4'd0;
    localparam logic [3:0] FlowInc         = 4'd1;
    localparam logic [3:0] FlowEof         = 4'd2;
    localparam logic [3:0] FlowIncEof      = 4'd3;
    localparam logic [3:0] FlowIncEofZ     = 4'd4;
    localparam logic [3:0] FlowIncEofNz    = 4'd5;
    localparam logic [3:0] FlowEofFu       = 4'd6;
    localparam logic [3:0] FlowIncEofFu    = 4'd7;
    localparam logic [3:0] FlowUpdateFlags = 4'd8;
    localparam logic [3:0] FlowNop         = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StCbDec,
        StExec
    } useq_state_e;

endpackage

// File: rtl/dzcpu_useq_next.sv
// Pure decode of a micro-op's flow field into strobes, end-of-instruction and the
// sequential next micro-address.
module dzcpu_useq_next
    import dzcpu_pkg::*;
#(
    parameter int unsigned UADDR_W = UaddrWDefault
) (
    input  logic [3:0]         uflow_i,
    input  logic               zflag_i,
    input  logic               ujcb_i,
    input  logic [UADDR_W-1:0] uaddr_i,
    output logic [UADDR_W-1:0] uaddr_next_o,
    output logic               uaddr_wrap_o,
    output logic               pc_inc_o,
    output logic               flags_update_o,
    output logic               end_o
);

    logic end_raw;

    always_comb begin
        pc_inc_o       = 1'b0;
        flags_update_o = 1'b0;
        end_raw        = 1'b0;
        case (uflow_i)
            FlowInc: begin
                pc_inc_o = 1'b1;
            end
            FlowEof: begin
                end_raw = 1'b1;
            end
            FlowIncEof: begin
                pc_inc_o = 1'b1;
                end_raw  = 1'b1;
            end
            FlowIncEofZ: begin
                pc_inc_o = 1'b1;
                end_raw  = zflag_i;
            end
            FlowIncEofNz: begin
                pc_inc_o = 1'b1;
                end_raw  = ~zflag_i;
            end
            FlowEofFu: begin
                flags_update_o = 1'b1;
                end_raw        = 1'b1;
            end
            FlowIncEofFu: begin
                pc_inc_o       = 1'b1;
                flags_update_o = 1'b1;
                end_raw        = 1'b1;
            end
            FlowUpdateFlags: begin
                flags_update_o = 1'b1;
            end
            default: ;
        endcase
        // A jcb micro-op always hops to the CB page, so its end code is dropped.
        end_o = end_raw & ~ujcb_i;
    end

    assign uaddr_next_o = uaddr_i + UADDR_W'(1);
    assign uaddr_wrap_o = &uaddr_i;

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu micro-sequencer: latches opcodes, walks their micro-op flows through the ROM,
// emits PC/flag strobes and counts retired instructions.
module dzcpu_useq
    import dzcpu_pkg::*;
#(
    parameter int unsigned UADDR_W = UaddrWDefault,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [7:0]         iMdata,
    input  logic               iMdataValid,
    input  logic               iStall,
    input  logic [UADDR_W-1:0] iFlowIdx,
    input  logic [UADDR_W-1:0] iCbFlowIdx,
    input  logic [3:0]         iUflow,
    input  logic               iUjcb,
    input  logic               iZflag,
    output logic [7:0]         oMop,
    output logic               oCbSel,
    output logic [UADDR_W-1:0] oUaddr,
    output logic               oFetchReq,
    output logic               oPcInc,
    output logic               oFlagsUpdate,
    output logic               oInstrDone,
    output logic [CNT_W-1:0]   oInstrCnt,
    output logic               oUerr
);

    useq_state_e        state_q, state_d;
    logic [7:0]         mop_q, mop_d;
    logic               cb_sel_q, cb_sel_d;
    logic [UADDR_W-1:0] uaddr_q, uaddr_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               uerr_q, uerr_d;

    logic [UADDR_W-1:0] uaddr_inc;
    logic               uaddr_wrap;
    logic               dec_pc_inc;
    logic               dec_flags_update;
    logic               dec_end;
    logic               exec_fire;

    dzcpu_useq_next #(
        .UADDR_W(UADDR_W)
    ) u_next (
        .uflow_i       (iUflow),
        .zflag_i       (iZflag),
        .ujcb_i        (iUjcb),
        .uaddr_i       (uaddr_q),
        .uaddr_next_o  (uaddr_inc),
        .uaddr_wrap_o  (uaddr_wrap),
        .pc_inc_o      (dec_pc_inc),
        .flags_update_o(dec_flags_update),
        .end_o         (dec_end)
    );

    // A jcb micro-op holds (no strobes) until the CB operand byte arrives.
    assign exec_fire = (state_q == StExec) && !iStall && !iReset && (!iUjcb || iMdataValid);

    assign oFetchReq    = (state_q == StFetch);
    assign oPcInc       = exec_fire & dec_pc_inc;
    assign oFlagsUpdate = exec_fire & dec_flags_update;

    always_comb begin
        state_d  = state_q;
        mop_d    = mop_q;
        cb_sel_d = cb_sel_q;
        uaddr_d  = uaddr_q;
        cnt_d    = cnt_q;
        uerr_d   = uerr_q;
        done_d   = 1'b0;
        if (!iStall) begin
            case (state_q)
                StIdle: begin
                    state_d = StFetch;
                end
                StFetch: begin
                    if (iMdataValid) begin
                        mop_d    = iMdata;
                        cb_sel_d = 1'b0;
                        state_d  = StDecode;
                    end
                end
                StDecode: begin
                    uaddr_d = iFlowIdx;
                    state_d = StExec;
                end
                StCbDec: begin
                    uaddr_d = iCbFlowIdx;
                    state_d = StExec;
                end
                StExec: begin
                    if (iUjcb) begin
                        if (iMdataValid) begin
                            mop_d    = iMdata;
                            cb_sel_d = 1'b1;
                            state_d  = StCbDec;
                        end
                    end else if (dec_end) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = StFetch;
                    end else begin
                        uaddr_d = uaddr_inc;
                        if (uaddr_wrap) begin
                            uerr_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q  <= StIdle;
            mop_q    <= 8'h00;
            cb_sel_q <= 1'b0;
            uaddr_q  <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            uerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mop_q    <= mop_d;
            cb_sel_q <= cb_sel_d;
            uaddr_q  <= uaddr_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            uerr_q   <= uerr_d;
        end
    end

    assign oMop       = mop_q;
    assign oCbSel     = cb_sel_q;
    assign oUaddr     = uaddr_q;
    assign oInstrDone = done_q;
    assign oInstrCnt  = cnt_q;
    assign oUerr      = uerr_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Scoreboard bench for dzcpu_useq: a behavioural LUT/ROM closes the loop and a monitor
// checks every retire against expectations queued by the stimulus.
module tb_dzcpu_useq;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic [7:0]  iMdata = 8'h00;
    logic        iMdataValid = 1'b0;
    logic        iStall = 1'b0;
    logic [7:0]  iFlowIdx;
    logic [7:0]  iCbFlowIdx;
    logic [3:0]  iUflow;
    logic        iUjcb;
    logic        iZflag = 1'b0;
    logic [7:0]  oMop;
    logic        oCbSel;
    logic [7:0]  oUaddr;
    logic        oFetchReq;
    logic        oPcInc;
    logic        oFlagsUpdate;
    logic        oInstrDone;
    logic [15:0] oInstrCnt;
    logic        oUerr;

    logic [3:0] rom_flow [256];
    logic       rom_jcb  [256];
    logic [7:0] lut      [256];
    logic [7:0] cblut    [256];

    typedef struct {
        logic [7:0]  mop;
        logic        cb;
        logic [7:0]  uaddr;
        logic [15:0] cnt;
        logic        uerr;
        int          pc;
        int          fu;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    logic exp_uerr = 1'b0;

    always #5 clk = ~clk;

    assign iUflow     = rom_flow[oUaddr];
    assign iUjcb      = rom_jcb[oUaddr];
    assign iFlowIdx   = lut[oMop];
    assign iCbFlowIdx = cblut[oMop];

    dzcpu_useq #(
        .UADDR_W(8),
        .CNT_W  (16)
    ) dut (
        .iClock      (clk),
        .iReset      (iReset),
        .iMdata      (iMdata),
        .iMdataValid (iMdataValid),
        .iStall      (iStall),
        .iFlowIdx    (iFlowIdx),
        .iCbFlowIdx  (iCbFlowIdx),
        .iUflow      (iUflow),
        .iUjcb       (iUjcb),
        .iZflag      (iZflag),
        .oMop        (oMop),
        .oCbSel      (oCbSel),
        .oUaddr      (oUaddr),
        .oFetchReq   (oFetchReq),
        .oPcInc      (oPcInc),
        .oFlagsUpdate(oFlagsUpdate),
        .oInstrDone  (oInstrDone),
        .oInstrCnt   (oInstrCnt),
        .oUerr       (oUerr)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] mop, input logic cb, input logic [7:0] ua,
                        input int pc, input int fu);
        exp_t e;
        exp_cnt++;
        e.mop   = mop;
        e.cb    = cb;
        e.uaddr = ua;
        e.cnt   = 16'(exp_cnt);
        e.uerr  = exp_uerr;
        e.pc    = pc;
        e.fu    = fu;
        sb.push_back(e);
    endtask

    // Returns one cycle after the opcode was presented (DECODE cycle, +1ns).
    task automatic issue(input logic [7:0] op);
        int n = 0;
        @(posedge clk); #1;
        while (oFetchReq !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (oFetchReq !== 1'b1) check("fetch_req_timeout", 32'(oFetchReq), 32'd1);
        iMdata      = op;
        iMdataValid = 1'b1;
        @(posedge clk); #1;
        iMdataValid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (oInstrDone !== 1'b1 && n < 60);
        if (oInstrDone !== 1'b1) check("retire_timeout", 32'(oInstrDone), 32'd1);
    endtask

    task automatic run(input logic [7:0] op, input logic [7:0] ua, input int pc, input int fu);
        push(op, 1'b0, ua, pc, fu);
        issue(op);
        wait_done();
    endtask

    task automatic do_reset(input bit mid);
        @(posedge clk); #1;
        iReset = 1'b1;
        @(negedge clk);
        if (mid) check("rst_cycle_no_pcinc", 32'(oPcInc), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_mop", 32'(oMop), 32'h00);
        check("rst_cbsel", 32'(oCbSel), 32'd0);
        check("rst_uaddr", 32'(oUaddr), 32'd0);
        check("rst_fetchreq", 32'(oFetchReq), 32'd0);
        check("rst_pcinc", 32'(oPcInc), 32'd0);
        check("rst_flagsupd", 32'(oFlagsUpdate), 32'd0);
        check("rst_done", 32'(oInstrDone), 32'd0);
        check("rst_cnt", 32'(oInstrCnt), 32'd0);
        check("rst_uerr", 32'(oUerr), 32'd0);
        @(posedge clk); #1;
        iReset   = 1'b0;
        exp_cnt  = 0;
        exp_uerr = 1'b0;
        @(negedge clk);
        check("release_cycle1_fetchreq", 32'(oFetchReq), 32'd0);
        @(negedge clk);
        check("release_cycle2_fetchreq", 32'(oFetchReq), 32'd1);
    endtask

    // Monitor: accumulates strobes and compares each retire against the scoreboard head.
    initial begin
        int   pc_acc = 0;
        int   fu_acc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (iReset === 1'b1) begin
                pc_acc = 0;
                fu_acc = 0;
            end else begin
                if (oPcInc === 1'b1) pc_acc++;
                if (oFlagsUpdate === 1'b1) fu_acc++;
                if (oInstrDone === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("retire_mop", 32'(oMop), 32'(e.mop));
                        check("retire_cbsel", 32'(oCbSel), 32'(e.cb));
                        check("retire_uaddr", 32'(oUaddr), 32'(e.uaddr));
                        check("retire_cnt", 32'(oInstrCnt), 32'(e.cnt));
                        check("retire_uerr", 32'(oUerr), 32'(e.uerr));
                        check("retire_pcinc_count", 32'(pc_acc), 32'(e.pc));
                        check("retire_flagsupd_count", 32'(fu_acc), 32'(e.fu));
                    end
                    pc_acc = 0;
                    fu_acc = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_flow[i] = 4'd2;
            rom_jcb[i]  = 1'b0;
            lut[i]      = 8'd0;
            cblut[i]    = 8'd0;
        end
        rom_flow[0] = 4'd3;
        lut[8'h31] = 8'd1;
        rom_flow[1] = 4'd1; rom_flow[2] = 4'd1; rom_flow[3] = 4'd0; rom_flow[4] = 4'd3;
        lut[8'h20] = 8'd8;
        rom_flow[8] = 4'd4; rom_flow[9] = 4'd2;
        lut[8'hCB] = 8'd12;
        rom_flow[12] = 4'd1; rom_jcb[12] = 1'b1;
        cblut[8'h7C] = 8'd16;
        rom_flow[16] = 4'd6;
        lut[8'h55] = 8'd255;
        rom_flow[255] = 4'd0;
        lut[8'h80] = 8'd32;
        rom_flow[32] = 4'd8; rom_flow[33] = 4'd7;
        lut[8'h28] = 8'd40;
        rom_flow[40] = 4'd5; rom_flow[41] = 4'd2;
        lut[8'h29] = 8'd42;
        rom_flow[42] = 4'd9; rom_flow[43] = 4'd3;

        do_reset(1'b0);

        // Unmapped opcode: single inc_eof, retires 3 cycles after fetch.
        push(8'hD3, 1'b0, 8'd0, 1, 0);
        issue(8'hD3);
        @(negedge clk);
        @(negedge clk);
        check("latency_exec_no_done", 32'(oInstrDone), 32'd0);
        @(negedge clk);
        check("latency_retire", 32'(oInstrDone), 32'd1);

        run(8'h31, 8'd4, 3, 0);

        iZflag = 1'b1;
        run(8'h20, 8'd8, 1, 0);
        iZflag = 1'b0;
        run(8'h20, 8'd9, 1, 0);

        // CB hop: operand byte offered from DECODE on; only the jcb micro-op takes it.
        push(8'h7C, 1'b1, 8'd16, 1, 1);
        issue(8'hCB);
        iMdata      = 8'h7C;
        iMdataValid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("cb_decode_ignores_valid", 32'(oMop), 32'hCB);
        @(posedge clk); #1;
        iMdataValid = 1'b0;
        @(negedge clk);
        check("cb_hop_mop", 32'(oMop), 32'h7C);
        check("cb_hop_cbsel", 32'(oCbSel), 32'd1);
        check("cb_hop_cbdec_uaddr", 32'(oUaddr), 32'd12);
        wait_done();

        // Stall across an inc_eof micro-op.
        push(8'h40, 1'b0, 8'd0, 1, 0);
        issue(8'h40);
        @(posedge clk); #1;
        iStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_no_pcinc", 32'(oPcInc), 32'd0);
            check("stall_no_done", 32'(oInstrDone), 32'd0);
            @(posedge clk); #1;
        end
        iStall = 1'b0;
        wait_done();

        exp_uerr = 1'b1;
        run(8'h55, 8'd0, 1, 0);
        run(8'h31, 8'd4, 3, 0);
        run(8'h80, 8'd33, 1, 2);
        run(8'h28, 8'd40, 1, 0);
        run(8'h29, 8'd43, 1, 0);

        // Abort an instruction mid-EXEC.
        issue(8'h31);
        do_reset(1'b1);
        run(8'hD3, 8'd0, 1, 0);

        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
